// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one full-subtractor
// stage per clock. Start/busy/done handshake; result and final borrow are
// registered and held until the next operation completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sd_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;

  logic             d_bit;
  logic             borrow_d;
  logic [WIDTH-1:0] sd_d;
  logic             last_bit;

  // Single full-subtractor cell operating on the current LSBs.
  always_comb begin
    d_bit    = sa_q[0] ^ sb_q[0] ^ borrow_q;
    borrow_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
    sd_d     = {d_bit, sd_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM with datapath shift registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      b_out    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            sa_q     <= a;
            sb_q     <= b;
            borrow_q <= b_in;
            sd_q     <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          sa_q     <= sa_q >> 1;
          sb_q     <= sb_q >> 1;
          sd_q     <= sd_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 1'b1;
          // Final stage publishes the result together with the done pulse.
          if (last_bit) begin
            diff    <= sd_d;
            b_out   <= borrow_d;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven checks for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

  int n_cmp;
  int n_bad;

  logic [WIDTH-1:0] held_diff;
  logic             held_bout;

  serial_subtractor #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .diff (diff),
    .b_out(b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vbin;
    logic [WIDTH-1:0] ediff;
    logic             ebout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation with cycle-accurate checks of busy/done/diff/b_out.
  task automatic do_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vbin, input logic [WIDTH-1:0] ediff, input logic ebout);
    @(negedge clk);
    a = va; b = vb; b_in = vbin; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_rise", {31'b0, busy}, 32'd1);
    start = 1'b0;
    // Operands after the accepting edge must not matter.
    a = WIDTH'($urandom); b = WIDTH'($urandom); b_in = 1'($urandom);
    for (int i = 1; i <= WIDTH; i++) begin
      @(posedge clk); #1;
      chk("done_timing", {31'b0, done}, (i == WIDTH) ? 32'd1 : 32'd0);
      chk("busy_hold", {31'b0, busy}, 32'd1);
      if (i < WIDTH) begin
        chk("diff_held", {28'b0, diff}, {28'b0, held_diff});
        chk("bout_held", {31'b0, b_out}, {31'b0, held_bout});
      end
    end
    chk("diff", {28'b0, diff}, {28'b0, ediff});
    chk("b_out", {31'b0, b_out}, {31'b0, ebout});
    held_diff = ediff;
    held_bout = ebout;
    @(posedge clk); #1;
    chk("done_fall", {31'b0, done}, 32'd0);
    chk("busy_fall", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [WIDTH:0] ref_v;
    logic [WIDTH-1:0] ra, rb;
    logic rbin;

    n_cmp = 0; n_bad = 0;
    held_diff = '0; held_bout = 1'b0;
    start = 1'b0; a = '0; b = '0; b_in = 1'b0;

    vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
    vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd12, 4'd5,  1'b0, 4'd7,  1'b0};
    vecs[5] = '{4'd5,  4'd12, 1'b1, 4'h8,  1'b1};
    vecs[6] = '{4'd0,  4'd15, 1'b1, 4'h0,  1'b1};
    vecs[7] = '{4'd15, 4'd0,  1'b1, 4'hE,  1'b0};
    vecs[8] = '{4'd8,  4'd8,  1'b1, 4'hF,  1'b1};
    vecs[9] = '{4'd10, 4'd3,  1'b1, 4'd6,  1'b0};

    rst_n = 1'b0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_diff", {28'b0, diff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_state", {26'b0, busy, done, diff, b_out}, 32'd0);
    end

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, vecs[i].ediff, vecs[i].ebout);

    // Start held high: back-to-back ops every WIDTH+2 cycles; mid-op operand
    // changes must be ignored.
    @(negedge clk);
    a = 4'd7; b = 4'd2; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int op = 0; op < 3; op++) begin
      for (int c = 1; c <= WIDTH + 2; c++) begin
        if (c == 2) begin a = 4'd1; b = 4'd14; b_in = 1'b1; end
        if (c == 5) begin a = 4'd7; b = 4'd2;  b_in = 1'b0; end
        @(posedge clk); #1;
        chk("b2b_done", {31'b0, done}, (c == WIDTH) ? 32'd1 : 32'd0);
        if (c >= WIDTH) chk("b2b_diff", {28'b0, diff}, 32'd5);
      end
    end
    start = 1'b0;
    a = 4'd1; b = 4'd14;
    for (int c = 1; c <= WIDTH + 2; c++) begin
      @(posedge clk); #1;
      chk("drain_done", {31'b0, done}, (c == WIDTH) ? 32'd1 : 32'd0);
      chk("drain_diff", {28'b0, diff}, 32'd5);
    end
    held_diff = 4'd5; held_bout = 1'b0;

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a = 4'd12; b = 4'd5; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {26'b0, busy, done, diff, b_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    held_diff = '0; held_bout = 1'b0;
    for (int c = 0; c < WIDTH + 2; c++) begin
      @(posedge clk); #1;
      chk("abort_quiet", {26'b0, busy, done, diff, b_out}, 32'd0);
    end
    do_op(4'd12, 4'd5, 1'b0, 4'd7, 1'b0);

    // Random operands against an arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
      ref_v = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
      do_op(ra, rb, rbin, ref_v[WIDTH-1:0], ref_v[WIDTH]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
